// File: rtl/ibex_pkg.sv
// Shared load/store types and small helpers for the data-side LSU slice.
package ibex_pkg;

  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10
  } ls_size_e;

  function automatic logic [3:0] ls_size_mask(ls_size_e size);
    logic [3:0] mask;
    unique case (size)
      LS_WORD: mask = 4'b1111;
      LS_HALF: mask = 4'b0011;
      default: mask = 4'b0001;
    endcase
    return mask;
  endfunction

  function automatic logic ls_misaligned(ls_size_e size, logic [1:0] offset);
    logic mis;
    unique case (size)
      LS_WORD: mis = (offset != 2'b00);
      LS_HALF: mis = (offset == 2'b11);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Merges the two halves of a split load, shifts the addressed bytes down and
// applies zero/sign extension for half-word and byte loads.
module ibex_lsu_rdata_align
  import ibex_pkg::*;
(
  input  logic [31:0] rdata_p1_i,
  input  logic [31:0] rdata_p2_i,
  input  logic        split_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] rdata_o
);

  logic [31:0] lo;
  logic [31:0] hi;
  logic [31:0] shifted;

  // Unsplit loads see the single bus word as both halves, i.e. a rotation.
  always_comb begin
    lo = split_i ? rdata_p1_i : rdata_p2_i;
    hi = rdata_p2_i;
    unique case (offset_i)
      2'd0:    shifted = lo;
      2'd1:    shifted = {hi[7:0],  lo[31:8]};
      2'd2:    shifted = {hi[15:0], lo[31:16]};
      default: shifted = {hi[23:0], lo[31:24]};
    endcase
  end

  always_comb begin
    unique case (ls_size_e'(size_i))
      LS_WORD: rdata_o = shifted;
      LS_HALF: rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_stage.sv
// Data-side load/store sequencer: bus handshake, misaligned splitting and
// formatted load/response delivery to writeback.
module ibex_lsu_resp_stage
  import ibex_pkg::*;
#(
  parameter bit SplitMisaligned = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic [31:0] addr_last_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT_MIS,
    WAIT_RVALID_MIS,
    WAIT_GNT,
    WAIT_RVALID
  } lsu_state_e;

  lsu_state_e  state_q;
  logic        we_q;
  logic        sign_ext_q;
  logic        mis_q;
  logic        err_q;
  logic        align_err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_last_q;

  logic        idle;
  logic        cur_we;
  ls_size_e    cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_mis;
  logic        part2;
  logic        final_rvalid;
  logic [7:0]  be_wide;
  logic [31:0] addr_aligned;
  logic [31:0] rdata_aligned;
  logic        resp_valid;
  logic        resp_err;
  logic        rf_we;

  // In IDLE the bus is driven straight from ID/EX; afterwards from the captured copy.
  always_comb begin
    idle      = (state_q == IDLE);
    cur_we    = idle ? lsu_we_i               : we_q;
    cur_size  = idle ? ls_size_e'(lsu_size_i) : ls_size_e'(size_q);
    cur_addr  = idle ? lsu_addr_i             : addr_q;
    cur_wdata = idle ? lsu_wdata_i            : wdata_q;
    cur_mis   = ls_misaligned(cur_size, cur_addr[1:0]);
  end

  always_comb begin
    part2 = (state_q == WAIT_RVALID_MIS) ||
            (((state_q == WAIT_GNT) || (state_q == WAIT_RVALID)) && mis_q);
    final_rvalid = (state_q == WAIT_RVALID) && data_rvalid_i;
  end

  always_comb begin
    unique case (state_q)
      IDLE:            data_req_o = lsu_req_i & ~(cur_mis & ~SplitMisaligned);
      WAIT_GNT_MIS,
      WAIT_GNT:        data_req_o = 1'b1;
      WAIT_RVALID_MIS: data_req_o = data_rvalid_i;
      default:         data_req_o = 1'b0;
    endcase
  end

  // The shifted 8-bit enable holds both parts: low nibble part 1, high nibble part 2.
  always_comb begin
    be_wide      = {4'b0000, ls_size_mask(cur_size)} << cur_addr[1:0];
    addr_aligned = {cur_addr[31:2], 2'b00};
    data_be_o    = part2 ? be_wide[7:4] : be_wide[3:0];
    data_addr_o  = part2 ? (addr_aligned + 32'd4) : addr_aligned;
    data_we_o    = cur_we;
    unique case (cur_addr[1:0])
      2'd0:    data_wdata_o = cur_wdata;
      2'd1:    data_wdata_o = {cur_wdata[23:0], cur_wdata[31:24]};
      2'd2:    data_wdata_o = {cur_wdata[15:0], cur_wdata[31:16]};
      default: data_wdata_o = {cur_wdata[7:0],  cur_wdata[31:8]};
    endcase
  end

  ibex_lsu_rdata_align u_rdata_align (
    .rdata_p1_i (rdata_q),
    .rdata_p2_i (data_rdata_i),
    .split_i    (mis_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .sign_ext_i (sign_ext_q),
    .rdata_o    (rdata_aligned)
  );

  always_comb begin
    resp_valid = align_err_q | final_rvalid;
    resp_err   = align_err_q | (final_rvalid & (err_q | data_err_i));
    rf_we      = resp_valid & ~we_q & ~resp_err;
  end

  assign lsu_resp_valid_o = resp_valid;
  assign lsu_resp_err_o   = resp_err;
  assign rf_we_lsu_o      = rf_we;
  assign rf_wdata_lsu_o   = rf_we ? rdata_aligned : '0;
  assign addr_last_o      = addr_last_q;
  assign busy_o           = ~idle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sign_ext_q  <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      align_err_q <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      addr_last_q <= '0;
    end else begin
      align_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            we_q       <= lsu_we_i;
            sign_ext_q <= lsu_sign_ext_i;
            size_q     <= lsu_size_i;
            addr_q     <= lsu_addr_i;
            wdata_q    <= lsu_wdata_i;
            mis_q      <= cur_mis & SplitMisaligned;
            err_q      <= 1'b0;
            if (cur_mis && !SplitMisaligned) begin
              align_err_q <= 1'b1;
            end else if (data_gnt_i) begin
              addr_last_q <= lsu_addr_i;
              state_q     <= cur_mis ? WAIT_RVALID_MIS : WAIT_RVALID;
            end else begin
              state_q <= cur_mis ? WAIT_GNT_MIS : WAIT_GNT;
            end
          end
        end
        WAIT_GNT_MIS: begin
          if (data_gnt_i) begin
            addr_last_q <= addr_q;
            state_q     <= WAIT_RVALID_MIS;
          end
        end
        WAIT_RVALID_MIS: begin
          if (data_rvalid_i) begin
            rdata_q <= data_rdata_i;
            err_q   <= data_err_i;
            if (data_gnt_i) begin
              addr_last_q <= data_addr_o;
              state_q     <= WAIT_RVALID;
            end else begin
              state_q <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) begin
            addr_last_q <= mis_q ? data_addr_o : addr_q;
            state_q     <= WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(lsu_req_i && !idle))
        else $error("lsu_req_i asserted while busy");
      assert (!(data_rvalid_i &&
                (state_q inside {IDLE, WAIT_GNT, WAIT_GNT_MIS})))
        else $error("data_rvalid_i without outstanding transaction");
      assert ($onehot0({resp_valid & rf_we,
                        data_req_o & resp_valid & ~part2}))
        else $error("response and new request overlap");
    end
  end

endmodule

// File: tb/tb_ibex_lsu_resp_stage.sv
// Directed bench for ibex_lsu_resp_stage with hand-computed expectations.
module tb_ibex_lsu_resp_stage;
  import ibex_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic [31:0] rf_wdata_lsu_o, addr_last_o;
  logic        rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, busy_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk_i = ~clk_i;

  ibex_lsu_resp_stage #(.SplitMisaligned(1'b1)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .data_req_o       (data_req_o),
    .data_gnt_i       (data_gnt_i),
    .data_addr_o      (data_addr_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_wdata_o     (data_wdata_o),
    .data_rvalid_i    (data_rvalid_i),
    .data_err_i       (data_err_i),
    .data_rdata_i     (data_rdata_i),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_err_o   (lsu_resp_err_o),
    .addr_last_o      (addr_last_o),
    .busy_o           (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic req(input logic we, input logic [1:0] size, input logic sext,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic gnt);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_sign_ext_i = sext;
    lsu_addr_i = addr; lsu_wdata_i = wdata; data_gnt_i = gnt;
  endtask

  task automatic bus(input logic gnt, input logic rvalid, input logic err, input logic [31:0] rdata);
    lsu_req_i = 1'b0; data_gnt_i = gnt; data_rvalid_i = rvalid;
    data_err_i = err; data_rdata_i = rdata;
  endtask

  initial begin
    rst_ni = 1'b0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_sign_ext_i = 0;
    lsu_addr_i = 0; lsu_wdata_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
    data_err_i = 0; data_rdata_i = 0;

    // reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst busy", busy_o, 0);
    chk("rst req", data_req_o, 0);
    chk("rst resp", lsu_resp_valid_o, 0);
    chk("rst rf_we", rf_we_lsu_o, 0);
    chk("rst addr_last", addr_last_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;

    // aligned LW 0x100
    @(negedge clk_i); req(0, LS_WORD, 0, 32'h100, 0, 1); #1;
    chk("lw req", data_req_o, 1);
    chk("lw addr", data_addr_o, 32'h100);
    chk("lw be", data_be_o, 4'hF);
    chk("lw we", data_we_o, 0);
    @(negedge clk_i); bus(0, 0, 0, 0); #1;
    chk("lw busy", busy_o, 1);
    chk("lw req off", data_req_o, 0);
    chk("lw no resp", lsu_resp_valid_o, 0);
    @(negedge clk_i); bus(0, 1, 0, 32'hDEADBEEF); #1;
    chk("lw resp", lsu_resp_valid_o, 1);
    chk("lw rf_we", rf_we_lsu_o, 1);
    chk("lw rdata", rf_wdata_lsu_o, 32'hDEADBEEF);
    chk("lw err", lsu_resp_err_o, 0);
    chk("lw addr_last", addr_last_o, 32'h100);
    @(negedge clk_i); bus(0, 0, 0, 0); #1;
    chk("lw idle", busy_o, 0);
    chk("lw resp drop", lsu_resp_valid_o, 0);

    // LB signed / LBU at 0x103
    @(negedge clk_i); req(0, LS_BYTE, 1, 32'h103, 0, 1); #1;
    chk("lb be", data_be_o, 4'b1000);
    chk("lb addr", data_addr_o, 32'h100);
    @(negedge clk_i); bus(0, 1, 0, 32'h80123456); #1;
    chk("lb rdata", rf_wdata_lsu_o, 32'hFFFFFF80);
    @(negedge clk_i); req(0, LS_BYTE, 0, 32'h103, 0, 1); data_rvalid_i = 0;
    @(negedge clk_i); bus(0, 1, 0, 32'h80123456); #1;
    chk("lbu rdata", rf_wdata_lsu_o, 32'h00000080);

    // LH signed aligned 0x102
    @(negedge clk_i); req(0, LS_HALF, 1, 32'h102, 0, 1); data_rvalid_i = 0; #1;
    chk("lh be", data_be_o, 4'b1100);
    @(negedge clk_i); bus(0, 1, 0, 32'h8001ABCD); #1;
    chk("lh rdata", rf_wdata_lsu_o, 32'hFFFF8001);

    // misaligned LW 0x102
    @(negedge clk_i); req(0, LS_WORD, 0, 32'h102, 0, 1); data_rvalid_i = 0; #1;
    chk("mlw p1 addr", data_addr_o, 32'h100);
    chk("mlw p1 be", data_be_o, 4'b1100);
    @(negedge clk_i); bus(1, 1, 0, 32'h55661234); #1;
    chk("mlw p2 req", data_req_o, 1);
    chk("mlw p2 addr", data_addr_o, 32'h104);
    chk("mlw p2 be", data_be_o, 4'b0011);
    chk("mlw p1 no resp", lsu_resp_valid_o, 0);
    @(negedge clk_i); bus(0, 1, 0, 32'hABCD7788); #1;
    chk("mlw resp", lsu_resp_valid_o, 1);
    chk("mlw rf_we", rf_we_lsu_o, 1);
    chk("mlw rdata", rf_wdata_lsu_o, 32'h77885566);
    chk("mlw addr_last", addr_last_o, 32'h104);
    @(negedge clk_i); bus(0, 0, 0, 0); #1;
    chk("mlw single resp", lsu_resp_valid_o, 0);
    chk("mlw idle", busy_o, 0);

    // misaligned SW 0x201, part-2 grant delayed one cycle
    @(negedge clk_i); req(1, LS_WORD, 0, 32'h201, 32'h11223344, 1); #1;
    chk("sw p1 addr", data_addr_o, 32'h200);
    chk("sw p1 be", data_be_o, 4'b1110);
    chk("sw wdata", data_wdata_o, 32'h22334411);
    chk("sw we", data_we_o, 1);
    @(negedge clk_i); bus(0, 1, 0, 0); #1;
    chk("sw p2 addr", data_addr_o, 32'h204);
    chk("sw p2 be", data_be_o, 4'b0001);
    chk("sw p2 wdata", data_wdata_o, 32'h22334411);
    @(negedge clk_i); bus(1, 0, 0, 0); #1;
    chk("sw p2 req held", data_req_o, 1);
    chk("sw p2 addr held", data_addr_o, 32'h204);
    @(negedge clk_i); bus(0, 1, 0, 0); #1;
    chk("sw resp", lsu_resp_valid_o, 1);
    chk("sw rf_we", rf_we_lsu_o, 0);
    chk("sw err", lsu_resp_err_o, 0);

    // misaligned LH 0x303 with part-1 bus error
    @(negedge clk_i); req(0, LS_HALF, 0, 32'h303, 0, 1); data_rvalid_i = 0; #1;
    chk("lherr p1 addr", data_addr_o, 32'h300);
    chk("lherr p1 be", data_be_o, 4'b1000);
    @(negedge clk_i); bus(1, 1, 1, 0); #1;
    chk("lherr p2 req", data_req_o, 1);
    chk("lherr p2 addr", data_addr_o, 32'h304);
    chk("lherr p2 be", data_be_o, 4'b0001);
    @(negedge clk_i); bus(0, 1, 0, 32'h000000AA); #1;
    chk("lherr resp", lsu_resp_valid_o, 1);
    chk("lherr err", lsu_resp_err_o, 1);
    chk("lherr rf_we", rf_we_lsu_o, 0);
    chk("lherr addr_last", addr_last_o, 32'h304);

    // address wrap on part 2
    @(negedge clk_i); req(0, LS_WORD, 0, 32'hFFFFFFFE, 0, 1); data_rvalid_i = 0; #1;
    chk("wrap p1 addr", data_addr_o, 32'hFFFFFFFC);
    @(negedge clk_i); bus(1, 1, 0, 32'hBBAA0000); #1;
    chk("wrap p2 addr", data_addr_o, 32'h00000000);
    @(negedge clk_i); bus(0, 1, 0, 32'h0000DDCC); #1;
    chk("wrap rdata", rf_wdata_lsu_o, 32'hDDCCBBAA);
    chk("wrap addr_last", addr_last_o, 32'h00000000);

    // grant delayed 3 cycles, then reset while waiting for rvalid
    @(negedge clk_i); req(0, LS_WORD, 0, 32'h400, 0, 0); data_rvalid_i = 0; #1;
    chk("dly req c0", data_req_o, 1);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk_i); bus(0, 0, 0, 0); lsu_addr_i = 32'hFFFFFFF0; #1;
      chk("dly req held", data_req_o, 1);
      chk("dly addr held", data_addr_o, 32'h400);
    end
    @(negedge clk_i); bus(1, 0, 0, 0); #1;
    chk("dly gnt addr", data_addr_o, 32'h400);
    @(negedge clk_i); bus(0, 0, 0, 0); #1;
    chk("dly busy", busy_o, 1);
    chk("dly addr_last", addr_last_o, 32'h400);
    rst_ni = 1'b0; #1;
    chk("midrst busy", busy_o, 0);
    chk("midrst resp", lsu_resp_valid_o, 0);
    chk("midrst addr_last", addr_last_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i); #1;
    chk("postrst busy", busy_o, 0);
    chk("postrst resp", lsu_resp_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
